sig_capture: RTL
================

# sig_capture

Single-trigger capture stage sitting directly downstream of the dual-channel sine generator. It takes the two phase-offset ROM samples (channel 1 and channel 2) on every enabled sample cycle and, once armed, waits for a rising crossing of a programmable level on channel 1. It then records a fixed-depth window of paired samples and streams them out over a valid/ready interface to the display/host side.

## Interface
Parameters:
- D_WIDTH, 8, width of each channel sample; matches the generator output width.
- DEPTH_LOG2, 6, log2 of capture depth (DEPTH = 2^DEPTH_LOG2 paired samples).
- TMO_WIDTH, 10, width of the auto-trigger timeout counter (used only with SIGCAP_AUTOTRIG_EN).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; the same enable that advances the generator's address counter.
- din1  input  D_WIDTH  channel 1 sample (generator dout1), unsigned offset-binary.
- din2  input  D_WIDTH  channel 2 sample (generator dout2).
- trig_level  input  D_WIDTH  trigger threshold, unsigned.
- arm  input  1  single-cycle request to start a capture; honoured only in IDLE.
- out_valid  output  1  out_data holds a captured sample.
- out_ready  input  1  consumer accepts out_data when high with out_valid.
- out_data  output  2*D_WIDTH  {ch1, ch2}; ch1 in the upper half.
- out_last  output  1  high with the final sample (index DEPTH-1).
- busy  output  1  high in any state other than IDLE.
- trig_forced  output  1  capture was started by timeout, not a real crossing.

## Operation
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE: arm=1 -> ARMED. Clear prev_valid, timeout counter, write/read pointers, trig_forced.
- ARMED: each en cycle, latch prev1 <= din1 and set prev_valid.
  - Trigger when prev_valid && prev1 < trig_level && din1 >= trig_level. The comparison is unsigned.
  - The triggering sample is written at index 0, wr_ptr <= 1, and the state moves to CAPTURE.
  - Cycles with en=0 are ignored entirely.
- CAPTURE: each en cycle, mem[wr_ptr] <= {din1,din2} and wr_ptr increments. The write at index DEPTH-1 moves the state to DRAIN. wr_ptr is DEPTH_LOG2 bits wide and wraps to 0.
- DRAIN:
  - out_valid=1, out_data = mem[rd_ptr], out_last = (rd_ptr == DEPTH-1).
  - On out_valid && out_ready, rd_ptr increments.
  - The handshake of the last sample moves the state to IDLE.
  - While in DRAIN, en and din are ignored, so generator samples during drain are discarded.
- arm is ignored outside IDLE. An arm pulse on the same cycle as the final handshake is ignored, because the state is still DRAIN on that edge.
- trig_level is sampled live every cycle, and changing it mid-ARMED takes effect immediately.
- Memory is a flop or distributed array and is not reset. Contents are valid only after a completed CAPTURE.

## Timing
- Reset (rst=0, asynchronous): state=IDLE. out_valid=0, out_data=0, out_last=0, busy=0, trig_forced=0. All pointers and counters are 0. The reset takes effect mid-capture or mid-drain without waiting for a clock.
- busy rises the cycle after the arm edge.
- Trigger sample latency: the sample present on the edge with en=1 that satisfies the crossing is stored at index 0 on that same edge.
- out_valid rises in the first cycle after the edge that writes index DEPTH-1.
- out_data is driven combinationally from mem[rd_ptr]. It is stable while out_valid && !out_ready.
- Throughput: one sample per cycle with out_ready held high, so drain takes exactly DEPTH cycles.
- busy falls the cycle after the last handshake.

## Configuration
- SIGCAP_AUTOTRIG_EN defined:
  - In ARMED, a TMO_WIDTH-bit counter increments on every en cycle that does not trigger.
  - On an en cycle with counter == 2^TMO_WIDTH-1 and no real crossing, a forced trigger occurs: the sample is stored at index 0, the state moves to CAPTURE, and trig_forced <= 1.
  - A real crossing on that same cycle takes priority, and trig_forced stays 0.
  - trig_forced holds until the next arm accepted in IDLE, or until reset.
- SIGCAP_AUTOTRIG_EN undefined: no counter is built, ARMED waits indefinitely, and trig_forced is tied 0.

## Test plan
Run with DEPTH_LOG2=4 (DEPTH=16), TMO_WIDTH=4.
- Reset mid-capture: arm, trigger, write 5 samples, drive rst=0 asynchronously between edges -> outputs immediately 0 and state IDLE. After release, out_valid stays 0 until a new arm and capture.
- Basic capture: din1 ramps 0x00,0x10,...,0xF0,0x00,... with en=1 each cycle, din2=~din1, trig_level=0x80, pulse arm -> index 0 = {0x80,0x7F}. Then 16 samples 0x80..0xF0,0x00..0x70 drain with out_last on {0x70,0x8F}, and busy falls.
- Sample strobe gating: same stimulus with en high every 3rd cycle -> identical captured data. out_valid rises exactly one cycle after the 16th enabled write.
- Backpressure: out_ready toggled 1,0,0,1,... during drain -> no sample lost or duplicated, and out_data is stable whenever valid && !ready.
- No false trigger: din1 held 0x90 with level 0x80, arm -> stays ARMED, because there is no below-to-above crossing. An arm pulse during DRAIN is ignored.
- Autotrigger (macro defined): din1 constant 0x20, level 0x80, arm -> forced trigger on the 16th enabled sample and trig_forced=1. With the macro undefined -> ARMED indefinitely and trig_forced=0.

Source files
------------

// File: rtl/sig_capture.sv
// sig_capture: single-trigger capture of paired generator samples on a rising ch1 level crossing.
// Latency: triggering sample stored on its own edge; out_valid rises the cycle after index DEPTH-1 is written.
// Backpressure: drain holds out_data/rd_ptr while out_ready is low; en/din are discarded while draining.
//
// Ports:
//   clk, rst (async active-low), en (sample strobe), din1/din2 (channel samples),
//   trig_level (unsigned threshold), arm (start request, honoured in IDLE only),
//   out_valid/out_ready/out_data/out_last (drain stream, {ch1,ch2}), busy, trig_forced.
// Optional feature: define SIGCAP_AUTOTRIG_EN to build the auto-trigger timeout counter.
module sig_capture #(
  parameter int D_WIDTH    = 8,
  parameter int DEPTH_LOG2 = 6,
  parameter int TMO_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [D_WIDTH-1:0]     din1,
  input  logic [D_WIDTH-1:0]     din2,
  input  logic [D_WIDTH-1:0]     trig_level,
  input  logic                   arm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*D_WIDTH-1:0]   out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   trig_forced
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [D_WIDTH-1:0]    prev1_q, prev1_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic                  trig_forced_q, trig_forced_d;

  // Sample storage is deliberately left unreset; it is only read in DRAIN,
  // which is reachable only after every location has been written.
  logic [2*D_WIDTH-1:0]  mem [DEPTH];
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;

  logic real_trig;
  logic forced_trig;
  logic trig_hit;

  // Rising crossing needs a previous enabled sample below the level and the
  // current one at or above it; trig_level is used live, never registered.
  assign real_trig = prev_valid_q && (prev1_q < trig_level) && (din1 >= trig_level);

`ifdef SIGCAP_AUTOTRIG_EN
  logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
  // Timeout fires only when the counter is saturated and no genuine crossing
  // is present, so a real trigger always wins and leaves trig_forced low.
  assign forced_trig = (tmo_q == {TMO_WIDTH{1'b1}}) && !real_trig;
`else
  assign forced_trig = 1'b0;
`endif

  assign trig_hit = real_trig || forced_trig;

  always_comb begin
    state_d       = state_q;
    prev1_d       = prev1_q;
    prev_valid_d  = prev_valid_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    trig_forced_d = trig_forced_q;
    mem_we        = 1'b0;
    mem_waddr     = wr_ptr_q;
`ifdef SIGCAP_AUTOTRIG_EN
    tmo_d         = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        prev_valid_d = 1'b0;
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
`ifdef SIGCAP_AUTOTRIG_EN
        tmo_d        = '0;
`endif
        if (arm) begin
          state_d       = S_ARMED;
          trig_forced_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (en) begin
          prev1_d      = din1;
          prev_valid_d = 1'b1;
          if (trig_hit) begin
            mem_we        = 1'b1;
            mem_waddr     = '0;
            wr_ptr_d      = PTR_ONE;
            state_d       = S_CAPTURE;
            trig_forced_d = forced_trig;
          end else begin
`ifdef SIGCAP_AUTOTRIG_EN
            tmo_d = tmo_q + 1'b1;
`endif
          end
        end
      end
      S_CAPTURE: begin
        if (en) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == PTR_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      default: begin // S_DRAIN
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == PTR_LAST) begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      prev1_q       <= '0;
      prev_valid_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      trig_forced_q <= 1'b0;
`ifdef SIGCAP_AUTOTRIG_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      prev1_q       <= prev1_d;
      prev_valid_q  <= prev_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      trig_forced_q <= trig_forced_d;
`ifdef SIGCAP_AUTOTRIG_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= {din1, din2};
    end
  end

  // Output data is gated to zero outside DRAIN so reset and idle present a
  // clean bus regardless of the unreset memory contents.
  assign out_valid   = (state_q == S_DRAIN);
  assign out_data    = out_valid ? mem[rd_ptr_q] : '0;
  assign out_last    = out_valid && (rd_ptr_q == PTR_LAST);
  assign busy        = (state_q != S_IDLE);
  assign trig_forced = trig_forced_q;

endmodule
